// File: rtl/cpu_top.sv
// Multicycle LoongArch32 subset core: 64-word instruction ROM, 256-word data RAM, CRMD/PRMD/ESTAT/ERA/EENTRY.
// Latency: FETCH, EXEC, WB = 3 cycles per instruction; LD.W/ST.W add LD_LAT MEM cycles; interrupt entry adds 1.
// No backpressure: the core runs freely and reports each retirement with a one-cycle pc_w_valid pulse.
module cpu_top #(
  parameter string INIT_FILE = "inst.mem",
  parameter int    LD_LAT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_intr,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data,
  output logic [31:0] pc_w,
  output logic        pc_w_valid
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

  localparam logic [31:0]   RESET_PC = 32'h1C00_0000;
  localparam int            CW       = (LD_LAT > 1) ? $clog2(LD_LAT) : 1;
  localparam logic [CW-1:0] MEM_LAST = CW'(LD_LAT - 1);

  logic [31:0] rom [0:63];
  logic [31:0] ram [0:255];
  logic [31:0] gr  [0:31];

  state_t        state;
  logic [31:0]   pc, ir, npc, res;
  logic [7:0]    widx;
  logic          wr_en_q;
  logic [CW-1:0] mem_cnt;
  logic          ie, pie;
  logic [31:0]   era;
  logic [25:0]   eentry;

  // Instruction fields and immediates; the architectural state they read is stable for the whole instruction.
  logic [4:0]  rd, rj, rk;
  logic [31:0] rj_val, rd_val, rk_val, simm12, offs16, offs26;
  logic [13:0] csr_num;
  logic        is_addi, is_lu12i, is_or, is_ld, is_st, is_b, is_beq, is_bne;
  logic        is_csrrd, is_csrwr, is_ertn, mem_last;

  assign rd       = ir[4:0];
  assign rj       = ir[9:5];
  assign rk       = ir[14:10];
  assign rj_val   = gr[rj];
  assign rd_val   = gr[rd];
  assign rk_val   = gr[rk];
  assign simm12   = {{20{ir[21]}}, ir[21:10]};
  assign offs16   = {{14{ir[25]}}, ir[25:10], 2'b00};
  assign offs26   = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};
  assign csr_num  = ir[23:10];
  assign is_addi  = (ir[31:22] == 10'h00A);
  assign is_lu12i = (ir[31:25] == 7'h0A);
  assign is_or    = (ir[31:15] == 17'h0002A);
  assign is_ld    = (ir[31:22] == 10'h0A2);
  assign is_st    = (ir[31:22] == 10'h0A6);
  assign is_b     = (ir[31:26] == 6'h14);
  assign is_beq   = (ir[31:26] == 6'h16);
  assign is_bne   = (ir[31:26] == 6'h17);
  assign is_csrrd = (ir[31:24] == 8'h04) && (rj == 5'd0);
  assign is_csrwr = (ir[31:24] == 8'h04) && (rj == 5'd1);
  assign is_ertn  = (ir == 32'h0648_3800);
  assign mem_last = (mem_cnt == MEM_LAST);

  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : gr[dbg_reg_addr];

  // CSR read mux: unimplemented numbers and unimplemented bits read as zero.
  logic [31:0] csr_rval;
  always_comb begin
    csr_rval = 32'd0;
    case (csr_num)
      14'h0:   csr_rval = {29'd0, ie, 2'b00};
      14'h1:   csr_rval = {29'd0, pie, 2'b00};
      14'h5:   csr_rval = {29'd0, ext_intr, 2'b00};
      14'h6:   csr_rval = era;
      14'hC:   csr_rval = {eentry, 6'd0};
      default: csr_rval = 32'd0;
    endcase
  end

  // Execute: result, register-write enable and branch resolution; anything undecoded is a NOP.
  logic [31:0] res_d, next_pc;
  logic        wr_en_d;
  always_comb begin
    res_d   = 32'd0;
    wr_en_d = 1'b0;
    next_pc = pc + 32'd4;
    if (is_addi)                   begin res_d = rj_val + simm12;     wr_en_d = 1'b1; end
    else if (is_lu12i)             begin res_d = {ir[24:5], 12'd0};   wr_en_d = 1'b1; end
    else if (is_or)                begin res_d = rj_val | rk_val;     wr_en_d = 1'b1; end
    else if (is_ld)                begin wr_en_d = 1'b1; end
    else if (is_csrrd || is_csrwr) begin res_d = csr_rval;            wr_en_d = 1'b1; end
    else if (is_b)                 next_pc = pc + offs26;
    else if (is_beq && (rj_val == rd_val)) next_pc = pc + offs16;
    else if (is_bne && (rj_val != rd_val)) next_pc = pc + offs16;
    else if (is_ertn)              next_pc = era;
  end

  // Control FSM and all architectural state except RAM; interrupts are taken only between instructions.
  always_ff @(posedge clk) begin
    pc_w_valid <= 1'b0;
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      npc     <= 32'd0;
      res     <= 32'd0;
      widx    <= 8'd0;
      wr_en_q <= 1'b0;
      mem_cnt <= '0;
      ie      <= 1'b0;
      pie     <= 1'b0;
      era     <= 32'd0;
      eentry  <= 26'd0;
      pc_w    <= 32'd0;
      for (int i = 0; i < 32; i++) gr[i] <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (ext_intr && ie) begin
            era <= pc;
            pie <= ie;
            ie  <= 1'b0;
            pc  <= {eentry, 6'd0};
          end else begin
            ir    <= rom[pc[7:2]];
            state <= EXEC;
          end
        end
        EXEC: begin
          npc     <= next_pc;
          res     <= res_d;
          wr_en_q <= wr_en_d;
          widx    <= 8'((rj_val + simm12) >> 2);
          mem_cnt <= '0;
          state   <= (is_ld || is_st) ? MEM : WB;
        end
        MEM: begin
          if (mem_last) begin
            if (is_ld) res <= ram[widx];
            state <= WB;
          end else begin
            mem_cnt <= mem_cnt + CW'(1);
          end
        end
        WB: begin
          if (wr_en_q && (rd != 5'd0)) gr[rd] <= res;
          if (is_csrwr) begin
            case (csr_num)
              14'h0:   ie     <= rd_val[2];
              14'h1:   pie    <= rd_val[2];
              14'h6:   era    <= rd_val;
              14'hC:   eentry <= rd_val[31:6];
              default: ;
            endcase
          end
          if (is_ertn) ie <= pie;
          pc         <= npc;
          pc_w       <= pc;
          pc_w_valid <= 1'b1;
          state      <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Data RAM keeps its contents across reset; a store commits in its last MEM cycle.
  always_ff @(posedge clk) begin
    if (!reset && (state == MEM) && mem_last && is_st) ram[widx] <= rd_val;
  end
endmodule

// File: tb/tb_cpu_top.sv
// Directed programs for cpu_top with a retirement scoreboard.
// Expected retirements (PC, one register value, cycles since previous retirement) are queued per program.
// A monitor pops one entry per pc_w_valid pulse and compares.
module tb_cpu_top;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_intr;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [31:0] pc_w;
  logic        pc_w_valid;

  cpu_top #(.INIT_FILE(""), .LD_LAT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .ext_intr     (ext_intr),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .pc_w         (pc_w),
    .pc_w_valid   (pc_w_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] v;
    int          gap;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h", name, act, want);
    end
  endtask

  task automatic p(input logic [31:0] off, input logic [31:0] word);
    dut.rom[off[7:2]] = word;
  endtask

  task automatic e(input logic [31:0] off, input logic [4:0] r, input logic [31:0] v, input int gap);
    exp_t x;
    x.pc = BASE + off; x.r = r; x.v = v; x.gap = gap;
    sbq.push_back(x);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) dut.rom[i] = 32'd0;
  endtask

  task automatic handler();
    p(32'h40, 32'h028004C6);   // ADDI.W r6,r6,1
    p(32'h44, 32'h06483800);   // ERTN
  endtask

  // Assert reset across two edges and check the output reset state.
  task automatic restart(input string tag);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, " reset pc_w"}, pc_w, 32'd0);
    chk({tag, " reset pc_w_valid"}, {31'd0, pc_w_valid}, 32'd0);
    clear_rom();
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 600) begin @(negedge clk); n++; end
    @(posedge clk);
    chk({tag, " outstanding retirements"}, sbq.size(), 32'd0);
    sbq.delete();
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string tag);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 300) begin
      @(negedge clk);
      hit = (pc_w_valid === 1'b1) && (pc_w === pc);
      n++;
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  // Monitor: one scoreboard entry per retirement pulse while entries remain.
  initial begin
    int   last;
    exp_t x;
    last = 0;
    dbg_reg_addr = 5'd0;
    forever begin
      @(negedge clk);
      if (pc_w_valid === 1'b1) begin
        if (sbq.size() > 0) begin
          x = sbq.pop_front();
          chk($sformatf("pc_w (want %08h)", x.pc), pc_w, x.pc);
          if (x.gap != 0) chk($sformatf("retire gap @%08h", x.pc), 32'(cyc - last), 32'(x.gap));
          dbg_reg_addr = x.r;
          #1;
          chk($sformatf("gr%0d @%08h", x.r, x.pc), dbg_reg_data, x.v);
        end
        last = cyc;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    ext_intr = 1'b0;

    // Program 1: ALU ops, GR0 discard, branches both ways, negative B, NOP, self-loop.
    clear_rom();
    p(32'h00, 32'h02816805); e(32'h00, 5'd5,  32'h0000005A, 0);
    p(32'h04, 32'h02801400); e(32'h04, 5'd0,  32'h00000000, 3);
    p(32'h08, 32'h02BFFC06); e(32'h08, 5'd6,  32'hFFFFFFFF, 3);
    p(32'h0C, 32'h142468A7); e(32'h0C, 5'd7,  32'h12345000, 3);
    p(32'h10, 32'h001514E8); e(32'h10, 5'd8,  32'h1234505A, 3);
    p(32'h14, 32'h5C0008A6); e(32'h14, 5'd9,  32'h00000000, 3);  // BNE taken
    p(32'h18, 32'h02800409);
    p(32'h1C, 32'h580008A6); e(32'h1C, 5'd9,  32'h00000000, 3);  // BEQ falls through
    p(32'h20, 32'h580008A5); e(32'h20, 5'd9,  32'h00000000, 3);  // BEQ taken
    p(32'h24, 32'h02800409);
    p(32'h28, 32'h5C0008A5); e(32'h28, 5'd9,  32'h00000000, 3);  // BNE falls through
    p(32'h2C, 32'h50000800); e(32'h2C, 5'd9,  32'h00000000, 3);
    p(32'h30, 32'h02800409);
    p(32'h34, 32'h02801C0A); e(32'h34, 5'd10, 32'h00000007, 3);
    p(32'h38, 32'h50000800); e(32'h38, 5'd10, 32'h00000007, 3);
    p(32'h40, 32'h53FFFFFF); e(32'h40, 5'd10, 32'h00000007, 3);  // B -4
    p(32'h3C, 32'h50000800); e(32'h3C, 5'd10, 32'h00000007, 3);
    p(32'h44, 32'hFFFFFFFF); e(32'h44, 5'd9,  32'h00000000, 3);  // undecoded -> NOP
    p(32'h48, 32'h50000000); e(32'h48, 5'd8,  32'h1234505A, 3);
    e(32'h48, 5'd8, 32'h1234505A, 3);
    #12;
    chk("p1 reset pc_w", pc_w, 32'd0);
    chk("p1 reset pc_w_valid", {31'd0, pc_w_valid}, 32'd0);
    #20 reset = 1'b0;
    drain("p1");

    // Program 2: store then loads (LD_LAT=3 gives 6-cycle retirement gap); address bits above [9:2] ignored.
    restart("p2");
    p(32'h00, 32'h02840001); e(32'h00, 5'd5, 32'h00000000, 0);
    p(32'h04, 32'h02816802); e(32'h04, 5'd2, 32'h0000005A, 3);
    p(32'h08, 32'h29800022); e(32'h08, 5'd1, 32'h00000100, 6);
    p(32'h0C, 32'h28800025); e(32'h0C, 5'd5, 32'h0000005A, 6);
    p(32'h10, 32'h28900024); e(32'h10, 5'd4, 32'h0000005A, 6);
    p(32'h14, 32'h50000000); e(32'h14, 5'd4, 32'h0000005A, 3);
    release_reset();
    drain("p2");

    // Program 3: interrupt raised while LD.W is in MEM; RAM contents survive reset.
    restart("p3");
    handler();
    p(32'h00, 32'h14380001); e(32'h00, 5'd1, 32'h1C000000, 0);
    p(32'h04, 32'h02810021); e(32'h04, 5'd1, 32'h1C000040, 3);
    p(32'h08, 32'h04003021); e(32'h08, 5'd1, 32'h00000000, 3);
    p(32'h0C, 32'h02801002); e(32'h0C, 5'd2, 32'h00000004, 3);
    p(32'h10, 32'h04000022); e(32'h10, 5'd2, 32'h00000000, 3);
    p(32'h14, 32'h02840001); e(32'h14, 5'd1, 32'h00000100, 3);
    p(32'h18, 32'h50005000); e(32'h18, 5'd5, 32'h00000000, 3);
    p(32'h68, 32'h28800025); e(32'h68, 5'd5, 32'h0000005A, 6);
    e(32'h40, 5'd6, 32'h00000001, 4);
    e(32'h44, 5'd6, 32'h00000001, 3);
    p(32'h6C, 32'h04001807); e(32'h6C, 5'd5, 32'h0000005A, 3);
    p(32'h70, 32'h028000C8); e(32'h70, 5'd7, 32'h1C00006C, 3);
    p(32'h74, 32'h50000000); e(32'h74, 5'd8, 32'h00000001, 3);
    release_reset();
    wait_pc(BASE + 32'h18, "p3 reach branch to load");
    repeat (3) @(posedge clk);
    #1 ext_intr = 1'b1;
    wait_pc(BASE + 32'h40, "p3 handler entry");
    ext_intr = 1'b0;
    drain("p3");

    // Program 4: pending interrupt ignored while IE=0, taken right after IE is set.
    restart("p4");
    handler();
    p(32'h00, 32'h14380001); e(32'h00, 5'd1, 32'h1C000000, 0);
    p(32'h04, 32'h02810021); e(32'h04, 5'd1, 32'h1C000040, 3);
    p(32'h08, 32'h04003021); e(32'h08, 5'd1, 32'h00000000, 3);
    p(32'h0C, 32'h02801002); e(32'h0C, 5'd2, 32'h00000004, 3);
    p(32'h10, 32'h04001403); e(32'h10, 5'd3, 32'h00000004, 3);  // ESTAT.IS mirrors ext_intr
    p(32'h14, 32'h04001804); e(32'h14, 5'd4, 32'h00000000, 3);  // ERA untouched
    p(32'h18, 32'h04000022); e(32'h18, 5'd2, 32'h00000000, 3);
    e(32'h40, 5'd6, 32'h00000001, 4);
    e(32'h44, 5'd6, 32'h00000001, 3);
    p(32'h1C, 32'h04001807); e(32'h1C, 5'd7, 32'h1C00001C, 3);
    p(32'h20, 32'h50000000); e(32'h20, 5'd7, 32'h1C00001C, 3);
    release_reset();
    ext_intr = 1'b1;
    wait_pc(BASE + 32'h40, "p4 handler entry");
    ext_intr = 1'b0;
    drain("p4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
